mem_access_ctrl: RTL
====================

# mem_access_ctrl

Initiator-side controller for the single-port block RAM: it accepts word write and burst read requests from the CPU datapath over a valid/ready handshake. It drives the RAM port (`en`, `we`, `addr`, `di`), accounts for the RAM's synchronous read latency and returns read data as a stream of `rsp_valid` beats. It sits between the CPU load/store logic and the 1K×16 data memory.

## Interface
- `ADDR_W`, default 10: RAM address width.
- `DATA_W`, default 16: RAM word width.
- `LEN_W`, default 4: burst length field width. A burst has `req_len + 1` beats, up to 16.
- `RD_LAT`, default 1, legal range ≥1: number of cycles from `ram_en` with `ram_we=0` on the port until `ram_dout` is valid.

Ports:
- `clock`  in  1  Sole clock; all registers update on the rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `req_valid`  in  1  Request present.
- `req_ready`  out  1  Controller can accept a request.
- `req_we`  in  1  1 = single-word write, 0 = burst read.
- `req_addr`  in  ADDR_W  Start address.
- `req_wdata`  in  DATA_W  Write data; ignored for reads.
- `req_len`  in  LEN_W  Read beats minus one; ignored for writes.
- `rsp_valid`  out  1  One-cycle pulse per read beat.
- `rsp_data`  out  DATA_W  Read word; valid only when `rsp_valid` is high.
- `rsp_last`  out  1  High with the final beat of a burst.
- `busy`  out  1  State is not IDLE.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_di`  out  DATA_W  RAM write data.
- `ram_dout`  in  DATA_W  RAM read data.

## Operation
- States:
  - IDLE: no access in progress.
  - WRITE: one write cycle on the RAM port.
  - READ: read addresses being issued.
  - DRAIN: waiting for in-flight read data to return.
- `req_ready = (state==IDLE) & ~reset`.
- A request is accepted on a rising edge where `req_valid & req_ready`. The requester holds all `req_*` fields stable until acceptance.
- All `ram_*` and `rsp_*` outputs are registered.
- **Write.** On accept, load `ram_en=1`, `ram_we=1`, `ram_addr=req_addr`, `ram_di=req_wdata`, and go to WRITE. At the next edge the RAM commits the word, `ram_en` and `ram_we` clear, and the state returns to IDLE. No response beat is produced.
- **Read.**
  - On accept, load `ram_en=1`, `ram_we=0`, `ram_addr=req_addr`, `cnt=req_len`, and go to READ.
  - Each READ edge with `cnt≠0`: `ram_addr` increments and `cnt` decrements. The increment is modulo 2^ADDR_W, so 1023→0 at the default width.
  - READ edge with `cnt==0`: `ram_en` clears and the state goes to DRAIN.
  - One beat is issued per cycle.
- **Response pipeline.** Every cycle with `ram_en & ~ram_we` pushes a token {valid, last=(cnt==0)} into a RD_LAT-deep shift register. When a token exits, `rsp_data←ram_dout`, `rsp_valid←1` and `rsp_last←token.last`.
- **DRAIN→IDLE** on the edge that loads the last beat. `req_ready` is therefore high in the same cycle `rsp_last` is high.
- There is no response backpressure; the consumer must take every beat.
- `rsp_data` holds its value when `rsp_valid` is low.

**Reset values** (asynchronous, take effect immediately): state=IDLE, `cnt`=0, pipeline tokens cleared, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_di`=0, `rsp_valid`=0, `rsp_last`=0, `rsp_data`=0, `busy`=0, `req_ready`=0.

**Boundary conditions:**
- Reset mid-burst or mid-write aborts the operation with no further beats. A write whose commit edge has not occurred is lost.
- `req_valid` while busy is not captured.
- `req_len=0` gives a single beat with `rsp_last=1`.

## Timing
- **Write:** accept edge E0; port active in cycle 1; committed at E1; `req_ready` high again in cycle 2. One write per 2 cycles.
- **Read, beat k:** on the port in cycle 1+k; `rsp_valid` in cycle 1+k+RD_LAT+1, i.e. cycle 3+k for RD_LAT=1.
- **Burst of N beats:** `rsp_last` in cycle N+RD_LAT+1. The next request can be accepted at the end of that cycle.
- **`busy`:** high from the cycle after accept through the cycle before `req_ready` returns.

## Structure
- Package `mem_ctrl_pkg` holds:
  - the state enum (IDLE, WRITE, READ, DRAIN);
  - the default widths ADDR_W=10, DATA_W=16, LEN_W=4;
  - the response token type {valid, last}.
- Sub-module `rd_lat_pipe`: a parameterised RD_LAT-deep shift register of tokens with async reset. The top level contains the FSM, the address/count registers and the output registers.

## Test plan
- Write 10→addr 2, 15→addr 3, 25→addr 4 back-to-back → `req_ready` low exactly 1 cycle after each accept. The RAM holds the values, checked by later reads.
- Burst read addr 2, len 2 → `rsp_data` 10, 15, 25 in cycles 3, 4, 5 after accept. `rsp_last` only on 25. `req_ready` high in cycle 5.
- Wrap read: preload 0xAAAA@1023 and 0x5555@0, then read addr 1023, len 1 → beats 0xAAAA then 0x5555. `ram_addr` goes 1023 then 0.
- `req_valid` held with a new write to addr 4 (20) during a 16-beat burst → not accepted until IDLE. The write then completes and a read of addr 4 returns 20.
- `reset` asserted in the middle of a 16-beat burst → all outputs zero immediately and no further `rsp_valid`. After release, `req_ready`=1 and a fresh len-0 read returns a single beat with `rsp_last`=1.
- RD_LAT=2 build, burst addr 2 len 2 → beats in cycles 4, 5, 6 after accept.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared state encoding, default widths and read-response token for the
// data-memory access controller.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef struct packed {
    logic valid;
    logic last;
  } rsp_tok_t;

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line that tracks read beats through the RAM's synchronous read
// latency so each token emerges in the cycle its data is on ram_dout.
module rd_lat_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clock,
  input  logic     reset,
  input  rsp_tok_t tok_in,
  output rsp_tok_t tok_out
);

  rsp_tok_t [RD_LAT-1:0] stage_r;

  // Token shift register; stage 0 holds the newest token
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= tok_in;
      for (int i = 1; i < RD_LAT; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tok_out = stage_r[RD_LAT-1];

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the single-port data RAM: single-word
// writes and burst reads, with read data returned as a beat stream.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  CNT_ZERO = {LEN_W{1'b0}};

  state_t            state_r, state_nxt_s;
  logic [LEN_W-1:0]  cnt_r, cnt_nxt_s;
  logic              ram_en_r, ram_en_nxt_s;
  logic              ram_we_r, ram_we_nxt_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_nxt_s;
  logic [DATA_W-1:0] ram_di_r, ram_di_nxt_s;
  logic              rsp_valid_r, rsp_last_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              accept_s;
  rsp_tok_t          tok_in_s, tok_out_s;

  assign req_ready = (state_r == ST_IDLE) & ~reset;
  assign accept_s  = req_valid & req_ready;
  assign busy      = (state_r != ST_IDLE);

  // Every read cycle on the port launches a token; last marks the final address
  always_comb begin
    tok_in_s       = '0;
    tok_in_s.valid = ram_en_r & ~ram_we_r;
    tok_in_s.last  = (cnt_r == CNT_ZERO);
  end

  rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_lat_pipe (
    .clock   (clock),
    .reset   (reset),
    .tok_in  (tok_in_s),
    .tok_out (tok_out_s)
  );

  // Next-state, address/count and RAM port decode
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    ram_en_nxt_s   = ram_en_r;
    ram_we_nxt_s   = ram_we_r;
    ram_addr_nxt_s = ram_addr_r;
    ram_di_nxt_s   = ram_di_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          ram_en_nxt_s   = 1'b1;
          ram_addr_nxt_s = req_addr;
          if (req_we) begin
            ram_we_nxt_s = 1'b1;
            ram_di_nxt_s = req_wdata;
            state_nxt_s  = ST_WRITE;
          end else begin
            ram_we_nxt_s = 1'b0;
            cnt_nxt_s    = req_len;
            state_nxt_s  = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        ram_en_nxt_s = 1'b0;
        ram_we_nxt_s = 1'b0;
        state_nxt_s  = ST_IDLE;
      end
      ST_READ: begin
        // Address wraps naturally at the top of the RAM
        if (cnt_r != CNT_ZERO) begin
          ram_addr_nxt_s = ram_addr_r + ADDR_ONE;
          cnt_nxt_s      = cnt_r - CNT_ONE;
        end else begin
          ram_en_nxt_s = 1'b0;
          state_nxt_s  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tok_out_s.valid & tok_out_s.last) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        ram_en_nxt_s = 1'b0;
        ram_we_nxt_s = 1'b0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // Control, RAM port and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      ram_en_r    <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_di_r    <= {DATA_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_last_r  <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ram_en_r    <= ram_en_nxt_s;
      ram_we_r    <= ram_we_nxt_s;
      ram_addr_r  <= ram_addr_nxt_s;
      ram_di_r    <= ram_di_nxt_s;
      rsp_valid_r <= tok_out_s.valid;
      rsp_last_r  <= tok_out_s.valid & tok_out_s.last;
      if (tok_out_s.valid) begin
        rsp_data_r <= ram_dout;
      end else begin
        rsp_data_r <= rsp_data_r;
      end
    end
  end

  assign ram_en    = ram_en_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = ram_addr_r;
  assign ram_di    = ram_di_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_last  = rsp_last_r;
  assign rsp_data  = rsp_data_r;

endmodule
